// File: rtl/red_pitaya_droplet_gen.sv
// rtl/red_pitaya_droplet_gen.sv - synthetic droplet fluorescence generator with sort-latency timer
//
// Plays a table of pulse amplitudes on the DAC as "droplets" (PULSE of width
// cycles, then GAP of gap cycles, baseline otherwise), counts sort triggers
// returned by the detector and measures trigger latency from each PULSE exit.
//
// Ports:
//   adc_clk_i, adc_rstn_i  clock, asynchronous active-low reset
//   dac_o                  registered signed DAC sample
//   sort_trig_i            sort trigger from the detector (adc_clk_i domain)
//   busy_o                 high while a droplet sequence runs
//   sys_*                  system bus (one-cycle ack, never errors)

module red_pitaya_droplet_gen #(
  parameter int DWT = 14,
  parameter int MEM = 32,
  parameter int SEQ = 4
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rstn_i,
  output logic signed [DWT-1:0] dac_o,
  input  logic                  sort_trig_i,
  output logic                  busy_o,
  input  logic [31:0]           sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic [3:0]            sys_sel,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_err,
  output logic                  sys_ack
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state_q, state_d;

  logic signed [DWT-1:0] baseline_q;
  logic [MEM-1:0]        width_q, gap_q, count_q;
  logic                  continuous_q;
  logic [MEM-1:0]        emitted_q, sort_events_q, last_lat_q, lat_cnt_q;
  logic                  armed_q;
  logic [SEQ-1:0]        idx_q;
  logic [MEM-1:0]        w_lat_q, g_lat_q, phase_q, phase_lim;
  logic                  sort_q;
  logic signed [DWT-1:0] amp_mem [2**SEQ];

  logic [19:0]    a20;
  logic           ctrl_wr, start_req, stop_req, amp_hit, sort_rise;
  logic [SEQ-1:0] amp_idx;
  logic           phase_done, enter_pulse, pulse_exit, start_go;
  logic [31:0]    rd_mux, status_w;
  logic           unused_bus;

  assign a20       = sys_addr[19:0];
  assign ctrl_wr   = sys_wen && (a20 == 20'h0);
  // stop has priority when both bits are written together
  assign stop_req  = ctrl_wr && sys_wdata[1];
  assign start_req = ctrl_wr && sys_wdata[0] && !sys_wdata[1];
  assign amp_hit   = (a20[19:12] == 8'h01) && (a20[11:SEQ+2] == '0);
  assign amp_idx   = a20[SEQ+1:2];
  assign sort_rise = sort_trig_i && !sort_q;
  assign unused_bus = ^{sys_sel, sys_addr, sys_wdata};

  assign phase_lim  = (state_q == PULSE) ? w_lat_q : g_lat_q;
  assign phase_done = (phase_q >= phase_lim);
  assign start_go   = enter_pulse && (state_q == IDLE);

  assign busy_o  = (state_q != IDLE);
  assign sys_err = 1'b0;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    enter_pulse = 1'b0;
    pulse_exit  = 1'b0;
    if (stop_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_req) begin
          state_d     = PULSE;
          enter_pulse = 1'b1;
        end
        PULSE: if (phase_done) begin
          state_d    = GAP;
          pulse_exit = 1'b1;
        end
        GAP: if (phase_done) begin
          // emitted already includes the droplet whose gap is ending
          if (!continuous_q && (emitted_q >= count_q)) begin
            state_d = IDLE;
          end else begin
            state_d     = PULSE;
            enter_pulse = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // droplet sequencer, latency timer and DAC output
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      w_lat_q       <= MEM'(1);
      g_lat_q       <= MEM'(1);
      phase_q       <= MEM'(1);
      emitted_q     <= '0;
      idx_q         <= '0;
      armed_q       <= 1'b0;
      lat_cnt_q     <= '0;
      last_lat_q    <= '0;
      sort_events_q <= '0;
      sort_q        <= 1'b0;
      dac_o         <= '0;
    end else begin
      sort_q <= sort_trig_i;
      if (sort_rise) sort_events_q <= sort_events_q + MEM'(1);

      if (enter_pulse) begin
        w_lat_q <= (width_q == '0) ? MEM'(1) : width_q;
        g_lat_q <= (gap_q == '0) ? MEM'(1) : gap_q;
        phase_q <= MEM'(1);
      end else if (pulse_exit) begin
        phase_q <= MEM'(1);
      end else if (state_q != IDLE) begin
        phase_q <= phase_q + MEM'(1);
      end

      if (start_go) begin
        emitted_q <= '0;
        idx_q     <= '0;
      end else if (pulse_exit) begin
        emitted_q <= emitted_q + MEM'(1);
        idx_q     <= idx_q + SEQ'(1);
      end

      if (start_go) begin
        armed_q <= 1'b0;
      end else begin
        if (armed_q && sort_rise) begin
          last_lat_q <= lat_cnt_q;
          armed_q    <= 1'b0;
        end
        // a new PULSE exit re-arms and restarts the count (1 in first GAP cycle)
        if (pulse_exit) begin
          armed_q   <= 1'b1;
          lat_cnt_q <= MEM'(1);
        end else if (armed_q && (lat_cnt_q != '1)) begin
          lat_cnt_q <= lat_cnt_q + MEM'(1);
        end
      end

      dac_o <= (state_q == PULSE) ? amp_mem[idx_q] : baseline_q;
    end
  end

  // amplitude table has no reset
  always_ff @(posedge adc_clk_i) begin
    if (sys_wen && amp_hit) amp_mem[amp_idx] <= sys_wdata[DWT-1:0];
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      baseline_q   <= '0;
      width_q      <= MEM'(1);
      gap_q        <= MEM'(1);
      count_q      <= MEM'(1);
      continuous_q <= 1'b0;
      sys_ack      <= 1'b0;
      sys_rdata    <= '0;
    end else begin
      sys_ack <= sys_wen || sys_ren;
      if (sys_ren) sys_rdata <= rd_mux;
      if (sys_wen) begin
        case (a20)
          20'h00: continuous_q <= sys_wdata[2];
          20'h04: baseline_q   <= sys_wdata[DWT-1:0];
          20'h08: width_q      <= MEM'(sys_wdata);
          20'h0C: gap_q        <= MEM'(sys_wdata);
          20'h10: count_q      <= MEM'(sys_wdata);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status_w            = '0;
    status_w[0]         = busy_o;
    status_w[SEQ+3:4]   = idx_q;
  end

  always_comb begin
    rd_mux = '0;
    if (amp_hit) begin
      rd_mux = 32'(amp_mem[amp_idx]);
    end else begin
      case (a20)
        20'h00: rd_mux = {29'd0, continuous_q, 2'b00};
        20'h04: rd_mux = 32'(baseline_q);
        20'h08: rd_mux = 32'(width_q);
        20'h0C: rd_mux = 32'(gap_q);
        20'h10: rd_mux = 32'(count_q);
        20'h14: rd_mux = status_w;
        20'h20: rd_mux = 32'(emitted_q);
        20'h24: rd_mux = 32'(sort_events_q);
        20'h28: rd_mux = 32'(last_lat_q);
        default: rd_mux = '0;
      endcase
    end
  end

endmodule
